// File: rtl/lcd_seq_pkg.sv
// Shared types and field widths for the LCD SPI command/data sequencer.
package lcd_seq_pkg;

   localparam int KIND_W    = 2;
   localparam int PAYLOAD_W = 8;
   localparam int WORD_W    = KIND_W + PAYLOAD_W;

   typedef enum logic [1:0] {
      K_CMD = 2'b00,
      K_DAT = 2'b01,
      K_DLY = 2'b10,
      K_CSR = 2'b11
   } kind_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DISPATCH,
      S_START,
      S_WAIT_HI,
      S_WAIT_LO,
      S_DELAY,
      S_GAP
   } state_e;

   // Extracts the kind tag from the top bits of a queued word.
   function automatic kind_e word_kind(input logic [WORD_W-1:0] word);
      return kind_e'(word[WORD_W-1 -: KIND_W]);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a push while full is dropped and
// a pop cannot make room for a same-cycle push.
module sync_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         i_push,
   input  logic                         i_pop,
   input  logic [WIDTH-1:0]             i_data,
   output logic [WIDTH-1:0]             o_data,
   output logic                         o_full,
   output logic                         o_empty,
   output logic [$clog2(DEPTH+1)-1:0]   o_level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [LW-1:0]    r_level;
   logic             w_push_ok;
   logic             w_pop_ok;

   assign o_full    = (r_level == LW'(DEPTH));
   assign o_empty   = (r_level == '0);
   assign w_push_ok = i_push & ~o_full;
   assign w_pop_ok  = i_pop & ~o_empty;
   assign o_data    = r_mem[r_rd_ptr];
   assign o_level   = r_level;

   // Storage array; contents need no reset because the pointers define validity.
   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop_ok) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/lcd_spi_sequencer.sv
// Sequencer feeding SpiMaster one byte at a time from a word FIFO, driving
// the LCD chip select and D/C lines and executing inline delay and
// chip-select-release words. CS_GAP must be at least 2.
module lcd_spi_sequencer
   import lcd_seq_pkg::*;
#(
   parameter int DEPTH      = 16,
   parameter int DELAY_UNIT = 12000,
   parameter int CS_GAP     = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         i_in_valid,
   output logic                         o_in_ready,
   input  logic [WORD_W-1:0]            i_in_word,
   output logic                         o_spi_start,
   output logic [PAYLOAD_W-1:0]         o_spi_data,
   input  logic                         i_spi_busy,
   output logic                         o_lcd_cs_n,
   output logic                         o_lcd_dc,
   output logic                         o_idle,
   output logic [$clog2(DEPTH+1)-1:0]   o_level
);

   localparam int CNT_W = PAYLOAD_W + $clog2(DELAY_UNIT + 1);
   // The idle cycle that pops the next word also shows CS high, so the gap
   // state itself runs one cycle short to keep the visible high time at CS_GAP.
   localparam logic [CNT_W-1:0] GAP_LOAD = (CS_GAP > 1) ? CNT_W'(CS_GAP - 1) : CNT_W'(1);

   state_e                 r_state;
   state_e                 w_next;
   logic [WORD_W-1:0]      r_word;
   logic [CNT_W-1:0]       r_cnt;
   logic [PAYLOAD_W-1:0]   r_spi_data;
   logic                   r_dc;
   logic                   r_cs_n;
   logic                   r_run;
   logic                   w_pop;
   logic                   w_full;
   logic                   w_empty;
   logic [WORD_W-1:0]      w_head;
   kind_e                  w_kind;
   kind_e                  w_head_kind;
   logic [PAYLOAD_W-1:0]   w_payload;
   logic [CNT_W-1:0]       w_dly_prod;

   assign w_kind      = word_kind(r_word);
   assign w_head_kind = word_kind(w_head);
   assign w_payload   = r_word[PAYLOAD_W-1:0];
   assign w_dly_prod  = CNT_W'(w_payload) * CNT_W'(DELAY_UNIT);

   assign o_in_ready  = r_run & ~w_full;
   assign o_spi_data  = r_spi_data;
   assign o_lcd_dc    = r_dc;
   assign o_lcd_cs_n  = r_cs_n;
   assign o_idle      = w_empty & (r_state == S_IDLE);

   sync_fifo #(
      .WIDTH (WORD_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (i_in_valid & o_in_ready),
      .i_pop   (w_pop),
      .i_data  (i_in_word),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (o_level)
   );

   // Holds in_ready low while reset is asserted and until the first clock after it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_run <= 1'b0;
      end else begin
         r_run <= 1'b1;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state decode plus the FIFO pop and the one-cycle SPI start strobe.
   always_comb begin
      w_next      = r_state;
      w_pop       = 1'b0;
      o_spi_start = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               w_pop  = 1'b1;
               w_next = S_DISPATCH;
            end
         end
         S_DISPATCH: begin
            case (w_kind)
               K_CMD, K_DAT: if (!i_spi_busy) w_next = S_START;
               K_DLY:        w_next = S_DELAY;
               K_CSR:        w_next = S_GAP;
               default:      w_next = S_IDLE;
            endcase
         end
         S_START: begin
            o_spi_start = 1'b1;
            w_next      = S_WAIT_HI;
         end
         S_WAIT_HI: if (i_spi_busy) w_next = S_WAIT_LO;
         S_WAIT_LO: if (!i_spi_busy) w_next = S_IDLE;
         S_DELAY:   if (r_cnt <= CNT_W'(1)) w_next = S_IDLE;
         S_GAP:     if (r_cnt <= CNT_W'(1)) w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   // Word latch, shared delay/gap counter and the registered LCD-side outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_word     <= '0;
         r_cnt      <= '0;
         r_spi_data <= '0;
         r_dc       <= 1'b0;
         r_cs_n     <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_pop) begin
                  r_word <= w_head;
                  if ((w_head_kind == K_CMD) || (w_head_kind == K_DAT)) begin
                     r_cs_n <= 1'b0;
                  end
               end
            end
            S_DISPATCH: begin
               case (w_kind)
                  K_CMD, K_DAT: begin
                     if (!i_spi_busy) begin
                        r_spi_data <= w_payload;
                        r_dc       <= (w_kind == K_DAT);
                        r_cs_n     <= 1'b0;
                     end
                  end
                  K_DLY: begin
                     r_cnt <= (w_payload == '0) ? CNT_W'(1) : w_dly_prod;
                  end
                  K_CSR: begin
                     r_cs_n <= 1'b1;
                     r_cnt  <= GAP_LOAD;
                  end
                  default: begin
                     r_cnt <= r_cnt;
                  end
               endcase
            end
            S_DELAY, S_GAP: begin
               r_cnt <= r_cnt - CNT_W'(1);
            end
            default: begin
               r_cnt <= r_cnt;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_spi_sequencer.sv
// Testbench for lcd_spi_sequencer: table-driven directed vectors, hand-written
// corner sequences and a randomized run checked against a transfer scoreboard.
module tb_lcd_spi_sequencer;
   import lcd_seq_pkg::*;

   localparam int DEPTH = 16;
   localparam int DU    = 10;
   localparam int GAP   = 4;
   localparam int LW    = $clog2(DEPTH+1);

   typedef struct {
      logic [9:0] word;
      logic [7:0] expData;
      logic       expDc;
      int         expLatency;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          inValid;
   logic [9:0]    inWord;
   logic          inReady;
   logic          spiStart;
   logic [7:0]    spiData;
   logic          spiBusy;
   logic          csN;
   logic          dc;
   logic          idle;
   logic [LW-1:0] level;

   int   checks = 0;
   int   errors = 0;

   logic busyModel;
   int   busyCnt;
   logic stall = 1'b0;

   logic [8:0] expq[$];
   logic [8:0] sbExp;
   bit   sbOn = 1'b0;
   bit   csWatch = 1'b0;
   int   csHighCnt = 0;

   lcd_spi_sequencer #(
      .DEPTH      (DEPTH),
      .DELAY_UNIT (DU),
      .CS_GAP     (GAP)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_in_valid  (inValid),
      .o_in_ready  (inReady),
      .i_in_word   (inWord),
      .o_spi_start (spiStart),
      .o_spi_data  (spiData),
      .i_spi_busy  (spiBusy),
      .o_lcd_cs_n  (csN),
      .o_lcd_dc    (dc),
      .o_idle      (idle),
      .o_level     (level)
   );

   always #5 clk = ~clk;

   // SpiMaster stand-in: busy rises the cycle after start and stays high 16 cycles;
   // the stall flag forces busy high to freeze the sequencer.
   assign spiBusy = busyModel | stall;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busyModel <= 1'b0;
         busyCnt   <= 0;
      end else if (spiStart) begin
         busyModel <= 1'b1;
         busyCnt   <= 16;
      end else if (busyCnt != 0) begin
         busyCnt <= busyCnt - 1;
         if (busyCnt == 1) busyModel <= 1'b0;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   // Pushes one word using the valid/ready handshake; returns just after the push edge.
   task automatic applyStimulus(input logic [9:0] w);
      int t;
      t = 0;
      @(negedge clk);
      inValid = 1'b1;
      inWord  = w;
      while (inReady !== 1'b1 && t < 3000) begin
         @(negedge clk);
         t++;
      end
      if (inReady !== 1'b1) begin
         checkOutput("push_timeout", {31'd0, inReady}, 1);
         inValid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      inValid = 1'b0;
   endtask

   // Counts cycles (sampled on negedges) until a start pulse is seen.
   task automatic waitStart(input int budget, output int lat);
      lat = 0;
      for (int i = 1; i <= budget; i++) begin
         @(negedge clk);
         if (spiStart === 1'b1) begin
            lat = i;
            return;
         end
      end
      checkOutput("start_timeout", 0, 1);
   endtask

   task automatic waitIdle(input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (idle === 1'b1 && spiBusy === 1'b0 && expq.size() == 0) return;
      end
      checkOutput("idle_timeout", 0, 1);
   endtask

   // Scoreboard: every start must carry the oldest outstanding CMD/DAT byte.
   always @(negedge clk) begin
      if (sbOn && rst_n === 1'b1 && spiStart === 1'b1) begin
         if (expq.size() == 0) begin
            checkOutput("unexpected_start", 1, 0);
         end else begin
            sbExp = expq.pop_front();
            checkOutput("sb_data", {24'd0, spiData}, {24'd0, sbExp[7:0]});
            checkOutput("sb_dc", {31'd0, dc}, {31'd0, sbExp[8]});
            checkOutput("sb_cs_low", {31'd0, csN}, 0);
            checkOutput("sb_busy_low", {31'd0, spiBusy}, 0);
         end
      end
      if (csWatch && csN !== 1'b0) csHighCnt++;
   end

   // Global time limit so the bench can never hang.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: actual timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Test sequence.
   initial begin
      vec_t       vecs[5];
      int         lat;
      int         starts;
      int         highRun;
      int         r;
      logic [9:0] w;
      logic [7:0] p;

      vecs[0] = '{10'h02A, 8'h2A, 1'b0, 3};
      vecs[1] = '{10'h100, 8'h00, 1'b1, 3};
      vecs[2] = '{10'h17F, 8'h7F, 1'b1, 3};
      vecs[3] = '{10'h0C3, 8'hC3, 1'b0, 3};
      vecs[4] = '{10'h15A, 8'h5A, 1'b1, 3};

      // Reset with valid asserted.
      rst_n   = 1'b0;
      inValid = 1'b1;
      inWord  = 10'h0AA;
      #12;
      checkOutput("rst_in_ready", {31'd0, inReady}, 0);
      checkOutput("rst_cs_n", {31'd0, csN}, 1);
      checkOutput("rst_dc", {31'd0, dc}, 0);
      checkOutput("rst_spi_start", {31'd0, spiStart}, 0);
      checkOutput("rst_spi_data", {24'd0, spiData}, 0);
      checkOutput("rst_idle", {31'd0, idle}, 1);
      checkOutput("rst_level", {27'd0, level}, 0);
      @(negedge clk);
      inValid = 1'b0;
      rst_n   = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checkOutput("post_rst_in_ready", {31'd0, inReady}, 1);
      checkOutput("post_rst_level", {27'd0, level}, 0);

      // Table-driven single transfers with latency, data and D/C checks.
      for (int i = 0; i < 5; i++) begin
         applyStimulus(vecs[i].word);
         waitStart(20, lat);
         checkOutput("vec_latency", lat, vecs[i].expLatency);
         checkOutput("vec_data", {24'd0, spiData}, {24'd0, vecs[i].expData});
         checkOutput("vec_dc", {31'd0, dc}, {31'd0, vecs[i].expDc});
         checkOutput("vec_cs_low", {31'd0, csN}, 0);
         checkOutput("vec_busy_low", {31'd0, spiBusy}, 0);
         csWatch = 1'b1;
         repeat (5) @(negedge clk);
         checkOutput("vec_data_hold", {24'd0, spiData}, {24'd0, vecs[i].expData});
         waitIdle(100);
      end
      csWatch = 1'b0;
      checkOutput("cs_low_throughout", csHighCnt, 0);

      // Delay word ahead of a command.
      sbOn = 1'b1;
      applyStimulus(10'h203);
      expq.push_back({1'b0, 8'h11});
      applyStimulus(10'h011);
      waitStart(200, lat);
      checkOutput("dly_min_wait", {31'd0, (lat + 1 >= 32)}, 1);
      checkOutput("dly_max_wait", {31'd0, (lat + 1 <= 40)}, 1);
      waitIdle(200);

      // CS release between two commands.
      expq.push_back({1'b0, 8'h01});
      applyStimulus(10'h001);
      applyStimulus(10'h300);
      expq.push_back({1'b0, 8'h02});
      applyStimulus(10'h002);
      starts  = 0;
      highRun = 0;
      for (int i = 0; i < 300 && starts < 2; i++) begin
         @(negedge clk);
         if (spiStart === 1'b1) starts++;
         else if (starts == 1 && csN === 1'b1) highRun++;
      end
      checkOutput("csr_two_starts", starts, 2);
      checkOutput("csr_gap_len", highRun, GAP);
      waitIdle(200);

      // Fill the FIFO while SpiMaster is stalled, then drop one extra push.
      stall = 1'b1;
      for (int i = 0; i < DEPTH + 1; i++) begin
         w = {2'b01, 8'(8'h40 + i)};
         expq.push_back({1'b1, w[7:0]});
         applyStimulus(w);
      end
      @(negedge clk);
      checkOutput("full_in_ready", {31'd0, inReady}, 0);
      checkOutput("full_level", {27'd0, level}, DEPTH);
      inValid = 1'b1;
      inWord  = 10'h1EE;
      @(posedge clk);
      #1;
      inValid = 1'b0;
      @(negedge clk);
      checkOutput("drop_level", {27'd0, level}, DEPTH);
      stall = 1'b0;
      waitIdle(3000);
      checkOutput("full_drain_empty", expq.size(), 0);

      // Reset in the middle of a transfer.
      expq.push_back({1'b0, 8'h33});
      applyStimulus(10'h033);
      applyStimulus(10'h044);
      waitStart(20, lat);
      repeat (5) @(negedge clk);
      checkOutput("pre_rst_busy", {31'd0, spiBusy}, 1);
      checkOutput("pre_rst_level", {27'd0, level}, 1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("rst_mid_cs", {31'd0, csN}, 1);
      checkOutput("rst_mid_level", {27'd0, level}, 0);
      checkOutput("rst_mid_idle", {31'd0, idle}, 1);
      expq.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      expq.push_back({1'b0, 8'h55});
      applyStimulus(10'h055);
      waitStart(20, lat);
      checkOutput("post_rst_latency", lat, 3);
      waitIdle(200);

      // Randomized word stream against the scoreboard.
      for (int n = 0; n < 40; n++) begin
         r = int'($urandom_range(0, 99));
         p = 8'($urandom);
         if (r < 40)      w = {2'b00, p};
         else if (r < 75) w = {2'b01, p};
         else if (r < 88) w = {2'b10, 8'($urandom_range(0, 2))};
         else             w = {2'b11, 8'h00};
         if (w[9:8] == 2'b00) expq.push_back({1'b0, w[7:0]});
         if (w[9:8] == 2'b01) expq.push_back({1'b1, w[7:0]});
         applyStimulus(w);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      waitIdle(20000);
      checkOutput("rand_drained", expq.size(), 0);
      checkOutput("rand_idle", {31'd0, idle}, 1);
      checkOutput("rand_level", {27'd0, level}, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
